turf_command_transmitter: RTL
=============================

TURF_COMMAND_TRANSMITTER -- requirements
Module: turf_command_transmitter

Interface
REQ-001 Parameter BIT_CLKS, default 16, SHALL set clk33_i cycles per UART bit, matching the SURF receiver's 16x-oversampled input.
REQ-002 Parameter GAP_BITS, default 2, SHALL set the number of idle-high bit periods inserted after each frame's last stop bit.
REQ-003 clk33_i  input  1  SHALL be the single 33 MHz clock; all logic is rising-edge.
REQ-004 rst_n_i  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 send_i  input  1  SHALL be the request strobe; accepted on a rising edge where send_i and ready_o are both high.
REQ-006 event_id_i  input  32  SHALL be the event ID, captured on acceptance.
REQ-007 buffer_i  input  2  SHALL be the LAB buffer number, captured on acceptance.
REQ-008 ready_o  output  1  SHALL be high when a request can be accepted.
REQ-009 busy_o  output  1  SHALL be high from acceptance through the end of the gap period.
REQ-010 cmd_o  output  1  SHALL be the registered serial command line; idle level high.
REQ-011 sent_o  output  1  SHALL pulse high for one cycle at the end of each frame's gap period.
REQ-012 drop_o  output  1  SHALL be a sticky flag set when send_i is high while ready_o is low.

Function
REQ-013 Frames SHALL have 7 bytes in this order: 0xA6; {6'b0, buffer}; event_id[31:24]; [23:16]; [15:8]; [7:0]; checksum.
REQ-014 Checksum SHALL be the modulo-256 sum of the four event ID bytes, discarding carries; header and LAB bytes are excluded.
REQ-015 Each byte SHALL be sent 8N1: one low start bit, 8 data bits LSB first, one high stop bit; each bit lasts exactly BIT_CLKS cycles.
REQ-016 Bytes within a frame SHALL be back-to-back, with no idle time between a stop bit and the next start bit.
REQ-017 States SHALL be IDLE, START, DATA, STOP, GAP.
  - IDLE -> START on acceptance or non-empty queue.
  - START -> DATA after one bit.
  - DATA -> STOP after 8 bits.
  - STOP -> START if bytes remain, else GAP.
  - GAP -> IDLE after GAP_BITS bits.
REQ-018 When a request is accepted in IDLE at edge N, cmd_o SHALL go low at edge N+1.
REQ-019 Frame length SHALL be 70*BIT_CLKS + GAP_BITS*BIT_CLKS cycles, which is 1152 cycles at the defaults.
REQ-020 Captured fields SHALL be held stable for the whole frame; changes on event_id_i or buffer_i after acceptance SHALL NOT affect the frame.
REQ-021 A request arriving while ready_o is low SHALL be ignored and SHALL set drop_o; drop_o SHALL clear only on reset.
REQ-022 Bit and byte counters SHALL wrap to 0 at each boundary; no frame SHALL contain more or fewer than 7 bytes.

Reset
REQ-023 Assertion of rst_n_i SHALL abort any frame immediately and force: state IDLE, cmd_o=1, ready_o=1, busy_o=0, sent_o=0, drop_o=0, queue empty.
REQ-024 A frame aborted by reset SHALL NOT be resumed; the downstream receiver discards partial frames while it hunts for 0xA6.
REQ-025 Deassertion of rst_n_i SHALL be synchronised to clk33_i before it releases the state machine.

Configuration
REQ-026 With CMD_TX_FIFO_EN defined, a 4-entry request FIFO of {buffer, event_id} SHALL be present.
  - ready_o = !full; requests are accepted while a frame is in flight.
  - Frames are sent in FIFO order, each separated by exactly GAP_BITS bits.
  - Accepting a request in the same cycle one is popped, when the FIFO is full, SHALL be permitted.
REQ-027 Without CMD_TX_FIFO_EN, a single holding register SHALL be used and ready_o SHALL equal !busy_o.

Structure
REQ-028 A shared package SHALL hold TX_HEADER (8'hA6), the frame byte count (7), and the FSM state encodings, shared with the SURF command receiver.
REQ-029 One sub-module, cmd_tx_fifo (4x34-bit synchronous FIFO), SHALL be instantiated only under CMD_TX_FIFO_EN.

Verification
REQ-030 Request event_id=0x12345678, buffer=2 -> bytes A6,02,12,34,56,78,14 on cmd_o; sent_o pulses 1152 cycles after acceptance.
REQ-031 Request event_id=0xFFFFFFFF, buffer=3 -> checksum 0xFC (carry discarded); looping the output into the SURF receiver gives event_id_ok=1 and digitize=4'b1000.
REQ-032 Second send_i asserted mid-frame without the FIFO -> request ignored, drop_o=1, first frame unaltered.
REQ-033 With CMD_TX_FIFO_EN, 5 back-to-back requests -> 4 accepted and 1 dropped; 4 frames out in order, each separated by 32 idle-high cycles.
REQ-034 rst_n_i pulsed low during byte 3 -> cmd_o high within the same cycle, outputs at reset values; the next request produces a clean frame.

Source files
------------

// File: rtl/turf_command_transmitter_pkg.sv
// Shared constants, FSM encoding and frame byte selection for the TURF->SURF
// serial command link (also used by the SURF command receiver).
package turf_command_transmitter_pkg;

  localparam logic [7:0] TX_HEADER   = 8'hA6;
  localparam int         FRAME_BYTES = 7;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_GAP   = 3'd4
  } tx_state_e;

  // Byte idx of a frame; index 6 (and the unused 7) carries the checksum,
  // an 8-bit wrap-around sum of the event ID bytes only.
  function automatic logic [7:0] frame_byte(input logic [2:0]  idx,
                                            input logic [1:0]  lab,
                                            input logic [31:0] id);
    logic [7:0] res;
    case (idx)
      3'd0:    res = TX_HEADER;
      3'd1:    res = {6'b0, lab};
      3'd2:    res = id[31:24];
      3'd3:    res = id[23:16];
      3'd4:    res = id[15:8];
      3'd5:    res = id[7:0];
      default: res = id[31:24] + id[23:16] + id[15:8] + id[7:0];
    endcase
    return res;
  endfunction

endpackage

// File: rtl/turf_command_transmitter_fifo.sv
// 4-entry synchronous request FIFO; head is presented combinationally and
// stays in place until popped, so the head is also the frame in flight.
module cmd_tx_fifo #(
  parameter int W = 34
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] data_o,
  output logic [2:0]   count_o,
  output logic         empty_o,
  output logic         full_o
);

  logic [W-1:0] mem_q [4];
  logic [1:0]   wr_q, rd_q;
  logic [2:0]   cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    case ({push_i, pop_i})
      2'b10:   cnt_d = cnt_q + 3'd1;
      2'b01:   cnt_d = cnt_q - 3'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + 2'd1;
      if (pop_i)  rd_q <= rd_q + 2'd1;
      cnt_q <= cnt_d;
    end
  end

  // A push into a full FIFO only happens alongside a pop, so overwriting the
  // departing head slot is safe.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_q];
  assign count_o = cnt_q;
  assign empty_o = (cnt_q == 3'd0);
  assign full_o  = (cnt_q == 3'd4);

endmodule

// File: rtl/turf_command_transmitter.sv
// TURF command transmitter: sends 7-byte 8N1 frames {A6, lab, id x4, csum}.
// Optional CMD_TX_FIFO_EN: 4-deep request queue instead of a holding register.
module turf_command_transmitter
  import turf_command_transmitter_pkg::*;
#(
  parameter int BIT_CLKS = 16,
  parameter int GAP_BITS = 2
) (
  input  logic        clk33_i,
  input  logic        rst_n_i,
  input  logic        send_i,
  input  logic [31:0] event_id_i,
  input  logic [1:0]  buffer_i,
  output logic        ready_o,
  output logic        busy_o,
  output logic        cmd_o,
  output logic        sent_o,
  output logic        drop_o
);

  localparam int CW = (BIT_CLKS > 1) ? $clog2(BIT_CLKS) : 1;
  localparam int GW = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;
  localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CLKS - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_BITS - 1);
  localparam logic [2:0]    BYTE_LAST = 3'(FRAME_BYTES - 1);

  // Reset asserts asynchronously but releases two clocks after rst_n_i rises.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge clk33_i or negedge rst_n_i) begin
    if (!rst_n_i) rst_sync_q <= 2'b00;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  tx_state_e     state_q, state_d;
  logic [CW-1:0] clk_q, clk_d;
  logic [2:0]    bit_q, bit_d;
  logic [2:0]    byte_q, byte_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          cmd_q, cmd_d;
  logic          sent_q, drop_q;

  logic          accept, queued, more, bit_end, gap_end;
  logic [33:0]   fld;
  logic [7:0]    cur_byte;

  assign bit_end = (clk_q == BIT_LAST);
  assign gap_end = (state_q == ST_GAP) && bit_end && (gap_q == GAP_LAST);
  assign busy_o  = (state_q != ST_IDLE);
  assign accept  = send_i && ready_o;

`ifdef CMD_TX_FIFO_EN
  logic       fifo_empty, fifo_full;
  logic [2:0] fifo_cnt;

  // The head entry stays queued until its gap ends, so it is the frame source.
  cmd_tx_fifo #(.W(34)) u_fifo (
    .clk_i   (clk33_i),
    .rst_n_i (rst_n),
    .push_i  (accept),
    .data_i  ({buffer_i, event_id_i}),
    .pop_i   (gap_end),
    .data_o  (fld),
    .count_o (fifo_cnt),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  assign ready_o = !fifo_full || gap_end;
  assign queued  = !fifo_empty;
  assign more    = (fifo_cnt > 3'd1) || accept;
`else
  logic [33:0] hold_q;

  always_ff @(posedge clk33_i or negedge rst_n) begin
    if (!rst_n)      hold_q <= '0;
    else if (accept) hold_q <= {buffer_i, event_id_i};
  end

  assign fld     = hold_q;
  assign ready_o = !busy_o;
  assign queued  = 1'b0;
  assign more    = 1'b0;
`endif

  assign cur_byte = frame_byte(byte_q, fld[33:32], fld[31:0]);

  always_comb begin
    state_d = state_q;
    clk_d   = clk_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    gap_d   = gap_q;
    if (state_q != ST_IDLE) clk_d = bit_end ? '0 : clk_q + 1'b1;
    case (state_q)
      ST_IDLE: begin
        clk_d  = '0;
        bit_d  = '0;
        byte_d = '0;
        gap_d  = '0;
        if (accept || queued) state_d = ST_START;
      end
      ST_START: if (bit_end) state_d = ST_DATA;
      ST_DATA: if (bit_end) begin
        if (bit_q == 3'd7) begin
          bit_d   = '0;
          state_d = ST_STOP;
        end else begin
          bit_d = bit_q + 1'b1;
        end
      end
      ST_STOP: if (bit_end) begin
        if (byte_q == BYTE_LAST) begin
          byte_d  = '0;
          state_d = ST_GAP;
        end else begin
          byte_d  = byte_q + 1'b1;
          state_d = ST_START;
        end
      end
      ST_GAP: if (bit_end) begin
        if (gap_end) begin
          gap_d   = '0;
          // A queued frame starts straight away so spacing is exactly the gap.
          state_d = more ? ST_START : ST_IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Line level follows the state one clock later, giving a registered output.
  always_comb begin
    cmd_d = 1'b1;
    case (state_q)
      ST_START: cmd_d = 1'b0;
      ST_DATA:  cmd_d = cur_byte[bit_q];
      default:  cmd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk33_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      clk_q   <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      gap_q   <= '0;
      cmd_q   <= 1'b1;
      sent_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      clk_q   <= clk_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      gap_q   <= gap_d;
      cmd_q   <= cmd_d;
      sent_q  <= gap_end;
      drop_q  <= drop_q || (send_i && !ready_o);
    end
  end

  assign cmd_o  = cmd_q;
  assign sent_o = sent_q;
  assign drop_o = drop_q;

endmodule
